// File: rtl/ahb_lite_master_if.sv
// Command/response handshake plus AHB-Lite bus signals for ahb_lite_master.
// The master modport is the initiator side; the slave modport is the bus target plus command source.
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    input  hrdata, hresp, hready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output hsel, haddr, htrans, hburst, hsize, hwrite, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
    output hrdata, hresp, hready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  hsel, haddr, htrans, hburst, hsize, hwrite, hwdata
  );
endinterface

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator (NONSEQ/SINGLE) with local rejection of bad commands.
// Optional macro AHB_MASTER_PIPELINE_EN overlaps the next address phase with the current data phase.
module ahb_lite_master (
  input  logic              clk,
  input  logic              n_rst,
  ahb_lite_master_if.master bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_ERR} state_t;

  typedef struct packed {
    logic        write;
    logic [3:0]  addr;
    logic [1:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  cmd_t        cmd_in;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        cmd_ready;
  logic        cmd_bad;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;

`ifdef AHB_MASTER_PIPELINE_EN
  cmd_t        nxt_q, nxt_d;
  logic        nxt_vld_q, nxt_vld_d;
  logic        nxt_rej_q, nxt_rej_d;
  logic        rej_due_q, rej_due_d;
`endif

  assign cmd_in = {bus.cmd_write, bus.cmd_addr, bus.cmd_size, bus.cmd_wdata};

  // Size 3 is unsupported; half-words and words must be naturally aligned.
  always_comb begin
    cmd_bad = (bus.cmd_size == 2'd3)
           || ((bus.cmd_size == 2'd1) && bus.cmd_addr[0])
           || ((bus.cmd_size == 2'd2) && (bus.cmd_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    cmd_ready   = 1'b0;
    hsel        = 1'b0;
    haddr       = '0;
    htrans      = HTRANS_IDLE;
    hsize       = '0;
    hwrite      = 1'b0;
    hwdata      = '0;
`ifdef AHB_MASTER_PIPELINE_EN
    nxt_d       = nxt_q;
    nxt_vld_d   = nxt_vld_q;
    nxt_rej_d   = nxt_rej_q;
    rej_due_d   = rej_due_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef AHB_MASTER_PIPELINE_EN
        // A rejection queued behind an earlier transfer is answered before taking new work.
        cmd_ready = n_rst && !rej_due_q;
        if (rej_due_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rej_due_d   = 1'b0;
        end
`else
        cmd_ready = n_rst;
`endif
        if (bus.cmd_valid && cmd_ready) begin
          if (cmd_bad) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            cmd_d   = cmd_in;
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = cmd_q.addr;
        hsize  = cmd_q.size;
        hwrite = cmd_q.write;
        if (bus.hready) begin
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        hwdata = cmd_q.write ? cmd_q.wdata : '0;
`ifdef AHB_MASTER_PIPELINE_EN
        cmd_ready = n_rst && !nxt_vld_q && !nxt_rej_q;
        if (nxt_vld_q) begin
          hsel   = 1'b1;
          htrans = HTRANS_NONSEQ;
          haddr  = nxt_q.addr;
          hsize  = nxt_q.size;
          hwrite = nxt_q.write;
        end
        if (bus.cmd_valid && cmd_ready) begin
          if (cmd_bad) begin
            nxt_rej_d = 1'b1;
          end else begin
            nxt_d     = cmd_in;
            nxt_vld_d = 1'b1;
          end
        end
`endif
        if (bus.hready) begin
          // A collapsed error (hresp with hready) completes here as an error.
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.hresp;
          rsp_rdata_d = (bus.hresp || cmd_q.write) ? '0 : bus.hrdata;
          state_d     = ST_IDLE;
`ifdef AHB_MASTER_PIPELINE_EN
          if (nxt_vld_q) begin
            cmd_d     = nxt_q;
            nxt_vld_d = 1'b0;
            state_d   = ST_DATA;
          end else if (nxt_vld_d) begin
            cmd_d     = nxt_d;
            nxt_vld_d = 1'b0;
            state_d   = ST_ADDR;
          end else if (nxt_rej_d) begin
            nxt_rej_d = 1'b0;
            rej_due_d = 1'b1;
          end
`endif
        end else if (bus.hresp) begin
          state_d = ST_ERR;
        end
      end

      ST_ERR: begin
        // Second error cycle: no address phase, any pending one stays parked.
        hwdata = cmd_q.write ? cmd_q.wdata : '0;
        if (bus.hready) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_IDLE;
`ifdef AHB_MASTER_PIPELINE_EN
          if (nxt_vld_q) begin
            cmd_d     = nxt_q;
            nxt_vld_d = 1'b0;
            state_d   = ST_ADDR;
          end else if (nxt_rej_q) begin
            nxt_rej_d = 1'b0;
            rej_due_d = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef AHB_MASTER_PIPELINE_EN
      nxt_q       <= '0;
      nxt_vld_q   <= 1'b0;
      nxt_rej_q   <= 1'b0;
      rej_due_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef AHB_MASTER_PIPELINE_EN
      nxt_q       <= nxt_d;
      nxt_vld_q   <= nxt_vld_d;
      nxt_rej_q   <= nxt_rej_d;
      rej_due_q   <= rej_due_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.hsel      = hsel;
  assign bus.haddr     = haddr;
  assign bus.htrans    = htrans;
  assign bus.hburst    = 3'b000;
  assign bus.hsize     = hsize;
  assign bus.hwrite    = hwrite;
  assign bus.hwdata    = hwdata;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: scripted scenarios plus randomized commands
// against a latency/response model derived from the command and the slave behaviour.
module tb_ahb_lite_master;
  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ahb_lite_master_if bus ();

  ahb_lite_master dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    int          lat;
    int          pulses;
    int          ns_cyc;
    int          ns_acc;
    int          ns_first;
    int          dp_first;
    logic        rdy;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  addr;
    logic [1:0]  size;
    logic        write;
    logic [31:0] wdata;
    logic        wd_stable;
    logic        err_idle;
  } obs_t;

  // Reference model: em 0 = OKAY, 1 = two-cycle ERROR, 2 = collapsed ERROR.
  function automatic logic m_bad(input logic [1:0] s, input logic [3:0] a);
    int bytes;
    bytes = 1 << s;
    return (s == 2'd3) || ((int'(a) % bytes) != 0);
  endfunction

  function automatic int m_lat(input logic bad, input int aw, input int dw, input int em);
    if (bad) return 1;
    return 3 + aw + dw + ((em == 1) ? 1 : 0);
  endfunction

  function automatic logic m_err(input logic bad, input int em);
    return bad || (em != 0);
  endfunction

  function automatic logic [31:0] m_rdata(input logic w, input logic err, input logic [31:0] rd);
    return (w || err) ? 32'd0 : rd;
  endfunction

  // Issues one command and plays a reactive slave; returns what was observed on the bus.
  task automatic run_cmd(input logic w, input logic [3:0] a, input logic [1:0] s,
                         input logic [31:0] wd, input int aw, input int dw, input int em,
                         input logic [31:0] rd, output obs_t o);
    int phase;
    int aw_left;
    int dw_left;
    phase = 0; aw_left = aw; dw_left = dw;
    o.lat = -1; o.pulses = 0; o.ns_cyc = 0; o.ns_acc = 0; o.ns_first = 0; o.dp_first = 0;
    o.err = 1'b0; o.rdata = '0; o.addr = '0; o.size = '0; o.write = 1'b0; o.wdata = '0;
    o.wd_stable = 1'b1; o.err_idle = 1'b0;
    @(negedge clk);
    o.rdy = bus.cmd_ready;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_size = s; bus.cmd_wdata = wd;
    bus.hready = 1'b1; bus.hresp = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_wdata = $urandom;
      bus.cmd_addr  = 4'($urandom_range(15));
      bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = $urandom;
      if (bus.rsp_valid) begin
        o.pulses++;
        if (o.lat < 0) begin
          o.lat = k; o.err = bus.rsp_err; o.rdata = bus.rsp_rdata;
        end
      end
      if (bus.htrans == 2'b10) begin
        o.ns_cyc++;
        if (o.ns_first == 0) o.ns_first = k;
      end
      case (phase)
        0: if (bus.htrans == 2'b10 && bus.hsel) begin
             o.addr = bus.haddr; o.size = bus.hsize; o.write = bus.hwrite;
             if (aw_left > 0) begin
               bus.hready = 1'b0; aw_left--;
             end else begin
               o.ns_acc++; phase = 1;
             end
           end
        1: begin
             if (o.dp_first == 0) begin
               o.dp_first = k; o.wdata = bus.hwdata;
             end else if (bus.hwdata !== o.wdata) begin
               o.wd_stable = 1'b0;
             end
             if (dw_left > 0) begin
               bus.hready = 1'b0; dw_left--;
             end else if (em == 0) begin
               bus.hrdata = rd; phase = 3;
             end else if (em == 1) begin
               bus.hready = 1'b0; bus.hresp = 1'b1; phase = 2;
             end else begin
               bus.hresp = 1'b1; phase = 3;
             end
           end
        2: begin
             o.err_idle = (bus.htrans == 2'b00);
             bus.hresp = 1'b1; phase = 3;
           end
        default: ;
      endcase
      if (o.lat >= 0 && k >= o.lat + 3) break;
    end
    bus.hready = 1'b1; bus.hresp = 1'b0;
    $display("txn w=%0d addr=0x%0h size=%0d aw=%0d dw=%0d em=%0d -> lat=%0d err=%0d rdata=0x%08h pulses=%0d",
             w, a, s, aw, dw, em, o.lat, o.err, o.rdata, o.pulses);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_wdata = '0;
    bus.hrdata = '0; bus.hresp = 1'b0; bus.hready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 0", bus.cmd_ready); end
    checks++; if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite} !== 10'd0) begin errors++; $display("FAIL rst_addr_sigs: got %0b/%0b/%0h/%0d/%0b want zeros", bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite); end
    checks++; if (bus.hburst !== 3'b000) begin errors++; $display("FAIL rst_hburst: got %0b want 000", bus.hburst); end
    checks++; if (bus.hwdata !== 32'd0) begin errors++; $display("FAIL rst_hwdata: got %08h want 0", bus.hwdata); end
    checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00 || bus.rsp_rdata !== 32'd0) begin errors++; $display("FAIL rst_rsp: got v=%0b e=%0b d=%08h want zeros", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    n_rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", bus.cmd_ready); end
  endtask

  task automatic test_word_write();
    obs_t o;
    run_cmd(1'b1, 4'h0, 2'd2, 32'hDEADBEEF, 0, 0, 0, 32'h0, o);
    checks++; if (o.rdy !== 1'b1) begin errors++; $display("FAIL ww_ready: got %0b want 1", o.rdy); end
    checks++; if (o.ns_first != 1) begin errors++; $display("FAIL ww_nonseq_cycle: got %0d want 1", o.ns_first); end
    checks++; if (o.addr !== 4'h0 || o.size !== 2'd2 || o.write !== 1'b1) begin errors++; $display("FAIL ww_addr_phase: got a=%0h s=%0d w=%0b want 0/2/1", o.addr, o.size, o.write); end
    checks++; if (o.dp_first != 2 || o.wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ww_hwdata: got cyc=%0d d=%08h want 2/DEADBEEF", o.dp_first, o.wdata); end
    checks++; if (o.lat != 3 || o.err !== 1'b0 || o.rdata !== 32'd0) begin errors++; $display("FAIL ww_rsp: got lat=%0d e=%0b d=%08h want 3/0/0", o.lat, o.err, o.rdata); end
    checks++; if (o.pulses != 1 || o.ns_acc != 1) begin errors++; $display("FAIL ww_counts: got pulses=%0d xfers=%0d want 1/1", o.pulses, o.ns_acc); end
  endtask

  task automatic test_byte_read();
    obs_t o;
    run_cmd(1'b0, 4'hC, 2'd0, 32'h0, 0, 0, 0, 32'h000000A5, o);
    checks++; if (o.addr !== 4'hC || o.size !== 2'd0 || o.write !== 1'b0) begin errors++; $display("FAIL br_addr_phase: got a=%0h s=%0d w=%0b want C/0/0", o.addr, o.size, o.write); end
    checks++; if (o.wdata !== 32'd0) begin errors++; $display("FAIL br_hwdata: got %08h want 0", o.wdata); end
    checks++; if (o.lat != 3 || o.err !== 1'b0 || o.rdata !== 32'h000000A5) begin errors++; $display("FAIL br_rsp: got lat=%0d e=%0b d=%08h want 3/0/000000A5", o.lat, o.err, o.rdata); end
  endtask

  task automatic test_reject();
    obs_t o;
    run_cmd(1'b0, 4'h5, 2'd1, 32'h0, 0, 0, 0, 32'h12345678, o);
    checks++; if (o.ns_cyc != 0) begin errors++; $display("FAIL rej_no_bus: got nonseq cycles=%0d want 0", o.ns_cyc); end
    checks++; if (o.lat != 1 || o.err !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL rej_rsp: got lat=%0d e=%0b d=%08h want 1/1/0", o.lat, o.err, o.rdata); end
    checks++; if (o.pulses != 1) begin errors++; $display("FAIL rej_pulses: got %0d want 1", o.pulses); end
    run_cmd(1'b1, 4'h2, 2'd3, 32'h1, 0, 0, 0, 32'h0, o);
    checks++; if (o.ns_cyc != 0 || o.lat != 1 || o.err !== 1'b1) begin errors++; $display("FAIL rej_size3: got ns=%0d lat=%0d e=%0b want 0/1/1", o.ns_cyc, o.lat, o.err); end
  endtask

  task automatic test_error();
    obs_t o;
    run_cmd(1'b1, 4'h4, 2'd0, 32'h0000005A, 0, 0, 1, 32'hFFFFFFFF, o);
    checks++; if (o.err_idle !== 1'b1) begin errors++; $display("FAIL err_htrans_idle: got %0b want 1", o.err_idle); end
    checks++; if (o.lat != 4 || o.err !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL err_rsp: got lat=%0d e=%0b d=%08h want 4/1/0", o.lat, o.err, o.rdata); end
    checks++; if (o.pulses != 1 || o.ns_acc != 1) begin errors++; $display("FAIL err_counts: got pulses=%0d xfers=%0d want 1/1", o.pulses, o.ns_acc); end
  endtask

  task automatic test_collapsed_error();
    obs_t o;
    run_cmd(1'b0, 4'h8, 2'd2, 32'h0, 0, 0, 2, 32'hCAFEF00D, o);
    checks++; if (o.lat != 3 || o.err !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL cerr_rsp: got lat=%0d e=%0b d=%08h want 3/1/0", o.lat, o.err, o.rdata); end
  endtask

  task automatic test_wait_states();
    obs_t o;
    run_cmd(1'b0, 4'h8, 2'd2, 32'h0, 0, 3, 0, 32'h13579BDF, o);
    checks++; if (o.lat != 6 || o.err !== 1'b0 || o.rdata !== 32'h13579BDF) begin errors++; $display("FAIL ws_read_rsp: got lat=%0d e=%0b d=%08h want 6/0/13579BDF", o.lat, o.err, o.rdata); end
    checks++; if (o.pulses != 1) begin errors++; $display("FAIL ws_read_pulses: got %0d want 1", o.pulses); end
    run_cmd(1'b1, 4'h2, 2'd1, 32'hA5A55A5A, 2, 2, 0, 32'h0, o);
    checks++; if (o.wd_stable !== 1'b1 || o.wdata !== 32'hA5A55A5A) begin errors++; $display("FAIL ws_hwdata_stable: got stable=%0b d=%08h want 1/A5A55A5A", o.wd_stable, o.wdata); end
    checks++; if (o.ns_cyc != 3 || o.lat != 7) begin errors++; $display("FAIL ws_addr_hold: got ns=%0d lat=%0d want 3/7", o.ns_cyc, o.lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wd;
    int          late_rsp;
    wd = $urandom;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 4'h8; bus.cmd_size = 2'd2; bus.cmd_wdata = wd;
    bus.hready = 1'b1; bus.hresp = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.hwdata !== wd) begin errors++; $display("FAIL rm_data_phase: got %08h want %08h", bus.hwdata, wd); end
    bus.hready = 1'b0;
    n_rst = 1'b0;
    @(negedge clk);
    bus.hready = 1'b1;
    checks++; if ({bus.hsel, bus.htrans, bus.haddr, bus.hsize, bus.hwrite} !== 10'd0 || bus.hwdata !== 32'd0) begin errors++; $display("FAIL rm_outputs: got sel=%0b tr=%0b a=%0h d=%08h want zeros", bus.hsel, bus.htrans, bus.haddr, bus.hwdata); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_rsp_ready: got v=%0b rdy=%0b want 0/0", bus.rsp_valid, bus.cmd_ready); end
    n_rst = 1'b1;
    late_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) late_rsp++;
    end
    checks++; if (late_rsp != 0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_no_rsp: got pulses=%0d rdy=%0b want 0/1", late_rsp, bus.cmd_ready); end
    $display("txn reset-abort write addr=0x8 wdata=0x%08h", wd);
  endtask

  task automatic test_random();
    obs_t        o;
    logic        w, bad;
    logic [3:0]  a;
    logic [1:0]  s;
    logic [31:0] wd, rd;
    int          aw, dw, em;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom_range(1)); a = 4'($urandom_range(15)); s = 2'($urandom_range(3));
      wd = $urandom; rd = $urandom;
      aw = $urandom_range(2); dw = $urandom_range(3); em = $urandom_range(2);
      bad = m_bad(s, a);
      run_cmd(w, a, s, wd, aw, dw, em, rd, o);
      checks++; if (o.rdy !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %0b want 1", i, o.rdy); end
      checks++; if (o.lat != m_lat(bad, aw, dw, em)) begin errors++; $display("FAIL rnd%0d_lat: got %0d want %0d", i, o.lat, m_lat(bad, aw, dw, em)); end
      checks++; if (o.err !== m_err(bad, em) || o.rdata !== m_rdata(w, m_err(bad, em), rd)) begin errors++; $display("FAIL rnd%0d_rsp: got e=%0b d=%08h want e=%0b d=%08h", i, o.err, o.rdata, m_err(bad, em), m_rdata(w, m_err(bad, em), rd)); end
      checks++; if (o.pulses != 1 || o.ns_acc != (bad ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_counts: got pulses=%0d xfers=%0d want 1/%0d", i, o.pulses, o.ns_acc, bad ? 0 : 1); end
      if (!bad) begin
        checks++; if (o.addr !== a || o.size !== s || o.write !== w || o.ns_cyc != aw + 1) begin errors++; $display("FAIL rnd%0d_addr_phase: got a=%0h s=%0d w=%0b ns=%0d want %0h/%0d/%0b/%0d", i, o.addr, o.size, o.write, o.ns_cyc, a, s, w, aw + 1); end
        checks++; if (o.wdata !== (w ? wd : 32'd0) || o.wd_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_hwdata: got %08h stable=%0b want %08h/1", i, o.wdata, o.wd_stable, w ? wd : 32'd0); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_reject();
    test_error();
    test_collapsed_error();
    test_wait_states();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
